issue_ctrl: RTL

In-order single-issue controller between the instruction source and the CPU datapath. It decodes each 32-bit instruction word and presents the decoded fields to the datapath one cycle later. It runs MUL/DIV on a shared multi-cycle multiply/divide unit (MDU) in the background while independent single-cycle instructions keep issuing. It stalls on operand hazards and MDU occupancy, and arbitrates the single register-file write port between the ALU/load path and the MDU.

---
 rtl/issue_ctrl_if.sv | 50 +++++
 rtl/issue_ctrl.sv | 125 ++++++++++++
 2 files changed

// File: rtl/issue_ctrl_if.sv
// Opcode package and the issue/write-back bundle between the
// instruction source, issue_ctrl and the datapath.
package issue_pkg;
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SW  = 4'd6;
  localparam logic [3:0] OP_BEQ = 4'd7;
  localparam logic [3:0] OP_BGT = 4'd8;
  localparam logic [3:0] OP_BGE = 4'd9;
  localparam logic [3:0] OP_MUL = 4'd10;
  localparam logic [3:0] OP_DIV = 4'd11;
endpackage

interface issue_ctrl_if;
  logic [31:0] instr_i;
  logic        instr_valid_i;
  logic        instr_ready_o;
  logic        iss_valid_o;
  logic [3:0]  iss_opcode_o;
  logic [4:0]  iss_ra_o;
  logic [4:0]  iss_rb_o;
  logic [4:0]  iss_rd_o;
  logic [12:0] iss_off_o;
  logic        mdu_start_o;
  logic        mdu_op_o;
  logic        wb_en_o;
  logic        wb_sel_o;
  logic [4:0]  wb_rd_o;
  logic        busy_o;

  modport master (
    output instr_i, instr_valid_i,
    input  instr_ready_o, iss_valid_o, iss_opcode_o,
    input  iss_ra_o, iss_rb_o, iss_rd_o, iss_off_o,
    input  mdu_start_o, mdu_op_o,
    input  wb_en_o, wb_sel_o, wb_rd_o, busy_o
  );

  modport slave (
    input  instr_i, instr_valid_i,
    output instr_ready_o, iss_valid_o, iss_opcode_o,
    output iss_ra_o, iss_rb_o, iss_rd_o, iss_off_o,
    output mdu_start_o, mdu_op_o,
    output wb_en_o, wb_sel_o, wb_rd_o, busy_o
  );
endinterface

// File: rtl/issue_ctrl.sv
// In-order single-issue controller with a background multi-cycle
// MUL/DIV unit sharing the single register-file write port.
module issue_ctrl
  import issue_pkg::*;
#(
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  issue_ctrl_if.slave bus
);
  localparam int MAX_LAT =
    (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW = $clog2(MAX_LAT + 1);

  typedef enum logic [1:0] {
    M_IDLE, M_RUN, M_WB
  } mstate_t;

  mstate_t       state;
  logic [CW-1:0] cnt;
  logic [4:0]    prd;

  logic [3:0] op;
  logic [4:0] ra, rb, rd, wdst;
  logic       is_alu, is_lw, is_mdu;
  logic       busy, hazard, port_clash, ready, acc;

  assign op = bus.instr_i[3:0];
  assign rd = bus.instr_i[8:4];
  assign rb = bus.instr_i[13:9];
  assign ra = bus.instr_i[18:14];

  always_comb begin
    is_alu = 1'b0;
    is_lw  = 1'b0;
    is_mdu = 1'b0;
    unique case (1'b1)
      (op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR}):
        is_alu = 1'b1;
      (op == OP_LW):
        is_lw = 1'b1;
      (op == OP_MUL || op == OP_DIV):
        is_mdu = 1'b1;
      default: ;
    endcase
  end

  assign wdst = is_lw ? rb : rd;
  assign busy = (state == M_RUN);

  // Conservative: any field matching the pending rd stalls.
  assign hazard = busy && (prd != '0) &&
                  (ra == prd || rb == prd || rd == prd);
  assign port_clash = busy && (cnt == '0) &&
                      (is_alu || is_lw);

  assign ready = !rst_i && !(busy && is_mdu) &&
                 !hazard && !port_clash;
  assign acc   = bus.instr_valid_i && ready;

  assign bus.instr_ready_o = ready;
  assign bus.busy_o        = busy;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state            <= M_IDLE;
      cnt              <= '0;
      prd              <= '0;
      bus.iss_valid_o  <= 1'b0;
      bus.iss_opcode_o <= '0;
      bus.iss_ra_o     <= '0;
      bus.iss_rb_o     <= '0;
      bus.iss_rd_o     <= '0;
      bus.iss_off_o    <= '0;
      bus.mdu_start_o  <= 1'b0;
      bus.mdu_op_o     <= 1'b0;
      bus.wb_en_o      <= 1'b0;
      bus.wb_sel_o     <= 1'b0;
      bus.wb_rd_o      <= '0;
    end else begin
      bus.iss_valid_o <= acc;
      bus.mdu_start_o <= 1'b0;
      bus.wb_en_o     <= acc && (is_alu || is_lw) &&
                         (wdst != '0);
      bus.wb_sel_o    <= 1'b0;
      bus.wb_rd_o     <= (acc && (is_alu || is_lw)) ?
                         wdst : '0;
      if (acc) begin
        bus.iss_opcode_o <= op;
        bus.iss_ra_o     <= ra;
        bus.iss_rb_o     <= rb;
        bus.iss_rd_o     <= rd;
        bus.iss_off_o    <= bus.instr_i[31:19];
      end
      unique case (state)
        M_IDLE, M_WB: begin
          state <= M_IDLE;
          if (acc && is_mdu) begin
            state           <= M_RUN;
            cnt             <= (op == OP_DIV) ?
                               CW'(DIV_LAT - 1) :
                               CW'(MUL_LAT - 1);
            prd             <= rd;
            bus.mdu_op_o    <= (op == OP_DIV);
            bus.mdu_start_o <= 1'b1;
          end
        end
        M_RUN: begin
          // Writers are stalled here, so the MDU owns the port.
          if (cnt == '0) begin
            state        <= M_WB;
            bus.wb_en_o  <= (prd != '0);
            bus.wb_sel_o <= 1'b1;
            bus.wb_rd_o  <= prd;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= M_IDLE;
      endcase
    end
  end
endmodule
